// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder that writes packed words to consecutive instruction-memory addresses.
// Optional macro ENCODER_RANGE_CHECK_EN adds immediate range checks to the illegal-bundle rules.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [ADDR_W:0] LP_MAX = (ADDR_W+1)'(MAX_WORDS);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addrPtr;
  logic [ADDR_W:0]   r_wordCount;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memWdata;
  logic              r_done;
  logic              r_err;

  logic              w_fire;
  logic              w_isShift;
  logic              w_fieldBad;
  logic              w_rangeBad;
  logic              w_illegal;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_countNext;

  assign w_fire      = in_valid & in_ready;
  assign w_isShift   = (in_kind == 3'd1) && (in_funct3 == 3'b001 || in_funct3 == 3'b101);
  assign w_countNext = r_wordCount + 1'b1;
  assign w_illegal   = w_fieldBad | w_rangeBad;

  always_comb begin
    w_word     = 32'd0;
    w_fieldBad = 1'b0;
    case (in_kind)
      3'd0: begin
        w_word     = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        w_fieldBad = in_funct7b5 && !(in_funct3 == 3'b000 || in_funct3 == 3'b101);
      end
      3'd1: begin
        if (w_isShift)
          w_word = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        w_fieldBad = in_funct7b5 && (in_funct3 != 3'b101);
      end
      3'd2: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      3'd3: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      3'd4: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], 7'b1100011};
      3'd5: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      3'd6: w_word = {in_imm[31:12], in_rd, 7'b0110111};
      default: w_fieldBad = 1'b1;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] w_immS;
  assign w_immS = in_imm;

  always_comb begin
    w_rangeBad = 1'b0;
    case (in_kind)
      3'd1:    w_rangeBad = w_isShift ? (in_imm > 32'd31) : (w_immS < -2048 || w_immS > 2047);
      3'd2,
      3'd3:    w_rangeBad = (w_immS < -2048 || w_immS > 2047);
      3'd4:    w_rangeBad = (w_immS < -4096 || w_immS > 4094 || in_imm[0]);
      3'd5:    w_rangeBad = (w_immS < -1048576 || w_immS > 1048574 || in_imm[0]);
      3'd6:    w_rangeBad = (in_imm[11:0] != 12'd0);
      default: w_rangeBad = 1'b0;
    endcase
  end
`else
  assign w_rangeBad = 1'b0;
`endif

  // Illegal bundles are consumed without a write, but their in_last still closes the session.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addrPtr   <= '0;
      r_wordCount <= '0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_memWe <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= RUN;
            r_addrPtr   <= base_addr;
            r_wordCount <= '0;
            r_err       <= 1'b0;
          end
        end
        RUN: begin
          if (w_fire) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_memWe     <= 1'b1;
              r_memAddr   <= r_addrPtr;
              r_memWdata  <= w_word;
              r_addrPtr   <= r_addrPtr + 1'b1;
              r_wordCount <= w_countNext;
            end
            if (in_last || (!w_illegal && w_countNext == LP_MAX))
              r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_state <= FIN;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == RUN);
  assign busy       = (r_state == RUN) || (r_state == DRAIN);
  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_wordCount;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a default instance plus a MAX_WORDS=2 instance.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_imm;
  logic        in_last;

  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [7:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [8:0]  word_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .MAX_WORDS(256)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  instr_encoder_loader #(.ADDR_W(8), .MAX_WORDS(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_kind(in_kind), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .busy(busy2), .done(done2), .err(err2), .word_count(word_count2)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBundle(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                           input logic [31:0] imm, input logic last);
    in_valid    = 1'b1;
    in_kind     = kind;
    in_rd       = rd;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_funct3   = f3;
    in_funct7b5 = f7b5;
    in_imm      = imm;
    in_last     = last;
  endtask

  task automatic beginSession(input logic [7:0] base);
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 00000", {in_ready, mem_we, busy, done, err});
    end
    total++;
    if ({mem_addr, mem_wdata, word_count} !== 49'd0) begin
      bad++; $display("[TB] FAIL reset_data: addr=%h wdata=%h cnt=%0d want zeros", mem_addr, mem_wdata, word_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] expWord[3];
    expWord[0] = 32'h00500093;
    expWord[1] = 32'h002081B3;
    expWord[2] = 32'h402081B3;
    beginSession(8'h10);
    total++;
    if ({in_ready, busy} !== 2'b11) begin
      bad++; $display("[TB] FAIL basic_run: ready/busy=%b want 11", {in_ready, busy});
    end
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: setBundle(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b0);
        1: setBundle(3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 32'd0, 1'b0);
        default: setBundle(3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 1'b1);
      endcase
      tick();
      total++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h10 + 8'(i), expWord[i]}) begin
        bad++; $display("[TB] FAIL basic_write%0d: we=%b addr=%h data=%h want 1 %h %h",
                        i, mem_we, mem_addr, mem_wdata, 8'h10 + 8'(i), expWord[i]);
      end
    end
    in_valid = 1'b0;
    total++;
    if ({in_ready, busy} !== 2'b01) begin
      bad++; $display("[TB] FAIL basic_drain: ready/busy=%b want 01", {in_ready, busy});
    end
    tick();
    total++;
    if ({done, busy, mem_we, word_count} !== {3'b100, 9'd3}) begin
      bad++; $display("[TB] FAIL basic_fin: done=%b busy=%b we=%b cnt=%0d want 1 0 0 3", done, busy, mem_we, word_count);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("[TB] FAIL basic_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_formats();
    logic [31:0] expWord[3];
    expWord[0] = 32'h0020A423;
    expWord[1] = 32'hFE208EE3;
    expWord[2] = 32'h008000EF;
    beginSession(8'h40);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: setBundle(3'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8, 1'b0);
        1: setBundle(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFFFFFC, 1'b0);
        default: setBundle(3'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8, 1'b1);
      endcase
      tick();
      total++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h40 + 8'(i), expWord[i]}) begin
        bad++; $display("[TB] FAIL format_write%0d: we=%b addr=%h data=%h want 1 %h %h",
                        i, mem_we, mem_addr, mem_wdata, 8'h40 + 8'(i), expWord[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_gaps();
    beginSession(8'h30);
    setBundle(3'd6, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000, 1'b0);
    tick();
    total++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h30, 32'h123452B7}) begin
      bad++; $display("[TB] FAIL gap_lui: we=%b addr=%h data=%h want 1 30 123452b7", mem_we, mem_addr, mem_wdata);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (mem_we !== 1'b0) begin
        bad++; $display("[TB] FAIL gap_idle%0d: we=%b want 0", i, mem_we);
      end
    end
    setBundle(3'd2, 5'd4, 5'd2, 5'd0, 3'b010, 1'b0, 32'hFFFFFFF0, 1'b1);
    tick();
    total++;
    if ({mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, 8'h31, 32'hFF012203, 1'b0}) begin
      bad++; $display("[TB] FAIL gap_lw: we=%b addr=%h data=%h rdy=%b want 1 31 ff012203 0",
                      mem_we, mem_addr, mem_wdata, in_ready);
    end
    setBundle(3'd0, 5'd7, 5'd7, 5'd7, 3'b000, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({mem_we, in_ready} !== 2'b00) begin
        bad++; $display("[TB] FAIL gap_after%0d: we/rdy=%b want 00", i, {mem_we, in_ready});
      end
    end
    total++;
    if (word_count !== 9'd2) begin
      bad++; $display("[TB] FAIL gap_count: got %0d want 2", word_count);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    beginSession(8'hFE);
    for (int i = 0; i < 3; i++) begin
      setBundle(3'd1, 5'd1, 5'd1, 5'd0, 3'b000, 1'b0, 32'd1, i == 2);
      tick();
      total++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'hFE + 8'(i), 32'h00108093}) begin
        bad++; $display("[TB] FAIL wrap_write%0d: we=%b addr=%h data=%h want 1 %h 00108093",
                        i, mem_we, mem_addr, mem_wdata, 8'hFE + 8'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if ({done, word_count} !== {1'b1, 9'd3}) begin
      bad++; $display("[TB] FAIL wrap_fin: done=%b cnt=%0d want 1 3", done, word_count);
    end
    tick();
  endtask

  task automatic test_max_words();
    base_addr = 8'h00;
    start2    = 1'b1;
    tick();
    start2    = 1'b0;
    setBundle(3'd1, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd7, 1'b0);
    tick();
    tick();
    total++;
    if ({mem_we2, mem_addr2, in_ready2, busy2} !== {1'b1, 8'h01, 1'b0, 1'b1}) begin
      bad++; $display("[TB] FAIL max_second: we=%b addr=%h rdy=%b busy=%b want 1 01 0 1",
                      mem_we2, mem_addr2, in_ready2, busy2);
    end
    tick();
    total++;
    if ({mem_we2, done2, word_count2} !== {2'b01, 9'd2}) begin
      bad++; $display("[TB] FAIL max_fin: we=%b done=%b cnt=%0d want 0 1 2", mem_we2, done2, word_count2);
    end
    tick();
    total++;
    if ({mem_we2, in_ready2, mem_we} !== 3'b000) begin
      bad++; $display("[TB] FAIL max_third: we2=%b rdy2=%b we1=%b want 000", mem_we2, in_ready2, mem_we);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal();
    beginSession(8'h20);
    setBundle(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b0);
    tick();
    setBundle(3'd7, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 1'b0);
    tick();
    total++;
    if ({mem_we, err, word_count} !== {2'b01, 9'd1}) begin
      bad++; $display("[TB] FAIL illegal_kind7: we=%b err=%b cnt=%0d want 0 1 1", mem_we, err, word_count);
    end
    setBundle(3'd0, 5'd3, 5'd1, 5'd2, 3'b001, 1'b1, 32'd0, 1'b0);
    tick();
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("[TB] FAIL illegal_rf7: we=%b want 0", mem_we);
    end
    setBundle(3'd1, 5'd3, 5'd1, 5'd0, 3'b101, 1'b1, 32'd3, 1'b0);
    tick();
    total++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h21, 32'h4030D193}) begin
      bad++; $display("[TB] FAIL illegal_next_srai: we=%b addr=%h data=%h want 1 21 4030d193", mem_we, mem_addr, mem_wdata);
    end
    setBundle(3'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 1'b1);
    tick();
    total++;
    if ({mem_we, in_ready, busy, err} !== 4'b0011) begin
      bad++; $display("[TB] FAIL illegal_last: we/rdy/busy/err=%b want 0011", {mem_we, in_ready, busy, err});
    end
    in_valid = 1'b0;
    tick();
    total++;
    if ({done, word_count} !== {1'b1, 9'd2}) begin
      bad++; $display("[TB] FAIL illegal_fin: done=%b cnt=%0d want 1 2", done, word_count);
    end
    tick();
    beginSession(8'h00);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("[TB] FAIL illegal_err_clear: err=%b want 0", err);
    end
    setBundle(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3000, 1'b1);
    tick();
`ifdef ENCODER_RANGE_CHECK_EN
    total++;
    if ({mem_we, err} !== 2'b01) begin
      bad++; $display("[TB] FAIL range_addi: we=%b err=%b want 0 1", mem_we, err);
    end
`else
    total++;
    if ({mem_we, mem_wdata, err} !== {1'b1, 32'hBB800093, 1'b0}) begin
      bad++; $display("[TB] FAIL trunc_addi: we=%b data=%h err=%b want 1 bb800093 0", mem_we, mem_wdata, err);
    end
`endif
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    beginSession(8'h50);
    setBundle(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 1'b0);
    tick();
    setBundle(3'd1, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd6, 1'b1);
    reset = 1'b1;
    tick();
    total++;
    if ({mem_we, busy, in_ready, done, err} !== 5'b0) begin
      bad++; $display("[TB] FAIL midreset_flags: got %b want 00000", {mem_we, busy, in_ready, done, err});
    end
    total++;
    if ({mem_addr, mem_wdata, word_count} !== 49'd0) begin
      bad++; $display("[TB] FAIL midreset_data: addr=%h data=%h cnt=%0d want zeros", mem_addr, mem_wdata, word_count);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({done, mem_we} !== 2'b00) begin
        bad++; $display("[TB] FAIL midreset_nodone%0d: done/we=%b want 00", i, {done, mem_we});
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; base_addr = '0;
    in_valid = 1'b0; in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7b5 = 1'b0; in_imm = '0; in_last = 1'b0;
    test_reset();
    test_basic();
    test_formats();
    test_gaps();
    test_wrap();
    test_max_words();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
